// File: rtl/branch_seq_pkg.sv
// Shared state encoding and branch read-port selects for the branch sequencer.
package branch_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_COPY,
    S_DRAIN,
    S_NEXT,
    S_FINISH
  } state_t;

  localparam logic [2:0] READ_SEL_MAXRELU = 3'b100;
  localparam logic [2:0] READ_SEL_NONE    = 3'b000;

endpackage

// File: rtl/result_copier.sv
// Streams RESULT_SIZE words from the branch read port into the output memory.
// Read data arrives one cycle after the address, so the write strobe and address trail by one cycle.
module result_copier #(
  parameter int ADDR_WIDTH  = 16,
  parameter int RESULT_SIZE = 169
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_out_base,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  output logic                  o_we,
  output logic [ADDR_WIDTH-1:0] o_waddr,
  output logic                  o_done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RESULT_SIZE - 1);

  logic                  r_active;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic                  w_last;

  // High in the cycle the final read address is on the port.
  assign w_last    = r_active && (r_cnt == LAST_ADDR);
  assign o_rd_addr = r_cnt;
  assign o_we      = r_we;
  assign o_waddr   = r_waddr;
  assign o_done    = w_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_we     <= 1'b0;
      r_waddr  <= '0;
    end else begin
      r_we <= r_active;
      if (r_active) begin
        r_waddr <= i_out_base + r_cnt;
      end
      if (i_start) begin
        r_active <= 1'b1;
        r_cnt    <= '0;
      end else if (w_last) begin
        r_active <= 1'b0;
        r_cnt    <= '0;
      end else if (r_active) begin
        r_cnt <= r_cnt + ADDR_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/branch_sequencer.sv
// Runs the branch once per output filter and copies each pooled result into the layer
// output memory at a per-filter offset; per-filter addresses are built with accumulators.
module branch_sequencer
  import branch_seq_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 16,
  parameter int NUM_FILTERS   = 4,
  parameter int RESULT_SIZE   = 169,
  parameter int KERNEL_STRIDE = 27,
  parameter int BIAS_BASE     = 0,
  parameter int OUT_BASE      = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] filter_idx,
  output logic                  branch_run,
  input  logic                  branch_done,
  output logic [ADDR_WIDTH-1:0] kernel_base,
  output logic [ADDR_WIDTH-1:0] bias_addr,
  output logic [2:0]            branch_read_select,
  output logic [ADDR_WIDTH-1:0] branch_read_address,
  input  logic [DATA_WIDTH-1:0] branch_result,
  output logic                  out_we,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data
);

  localparam logic [ADDR_WIDTH-1:0] LAST_FILTER = ADDR_WIDTH'(NUM_FILTERS - 1);
  localparam logic [ADDR_WIDTH-1:0] K_STRIDE    = ADDR_WIDTH'(KERNEL_STRIDE);
  localparam logic [ADDR_WIDTH-1:0] R_STRIDE    = ADDR_WIDTH'(RESULT_SIZE);

  state_t                r_state;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_run;
  logic [ADDR_WIDTH-1:0] r_filter_idx;
  logic [ADDR_WIDTH-1:0] r_kernel_base;
  logic [ADDR_WIDTH-1:0] r_bias_addr;
  logic [ADDR_WIDTH-1:0] r_out_base;
  logic [2:0]            r_read_sel;

  logic                  w_copy_start;
  logic                  w_copy_last;
  logic                  w_we;

  // The copier must be issuing address 0 in the first COPY cycle, so it starts on the WAIT exit.
  assign w_copy_start = (r_state == S_WAIT) && branch_done;

  result_copier #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESULT_SIZE(RESULT_SIZE)
  ) u_copier (
    .clk       (clk),
    .rst       (reset),
    .i_start   (w_copy_start),
    .i_out_base(r_out_base),
    .o_rd_addr (branch_read_address),
    .o_we      (w_we),
    .o_waddr   (out_addr),
    .o_done    (w_copy_last)
  );

  assign busy               = r_busy;
  assign done               = r_done;
  assign branch_run         = r_run;
  assign filter_idx         = r_filter_idx;
  assign kernel_base        = r_kernel_base;
  assign bias_addr          = r_bias_addr;
  assign branch_read_select = r_read_sel;
  assign out_we             = w_we;
  assign out_data           = w_we ? branch_result : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_run         <= 1'b0;
      r_filter_idx  <= '0;
      r_kernel_base <= '0;
      r_bias_addr   <= '0;
      r_out_base    <= '0;
      r_read_sel    <= READ_SEL_NONE;
    end else begin
      r_done <= 1'b0;
      r_run  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state       <= S_LAUNCH;
            r_busy        <= 1'b1;
            r_run         <= 1'b1;
            r_filter_idx  <= '0;
            r_kernel_base <= '0;
            r_bias_addr   <= ADDR_WIDTH'(BIAS_BASE);
            r_out_base    <= ADDR_WIDTH'(OUT_BASE);
          end
        end
        S_LAUNCH: r_state <= S_WAIT;
        S_WAIT: begin
          if (branch_done) begin
            r_state    <= S_COPY;
            r_read_sel <= READ_SEL_MAXRELU;
          end
        end
        S_COPY: begin
          if (w_copy_last) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          r_state    <= S_NEXT;
          r_read_sel <= READ_SEL_NONE;
        end
        S_NEXT: begin
          if (r_filter_idx == LAST_FILTER) begin
            r_state <= S_FINISH;
            r_done  <= 1'b1;
          end else begin
            r_state       <= S_LAUNCH;
            r_run         <= 1'b1;
            r_filter_idx  <= r_filter_idx + ADDR_WIDTH'(1);
            r_kernel_base <= r_kernel_base + K_STRIDE;
            r_bias_addr   <= r_bias_addr + ADDR_WIDTH'(1);
            r_out_base    <= r_out_base + R_STRIDE;
          end
        end
        S_FINISH: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
          r_read_sel <= READ_SEL_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_sequencer.sv
// Bench for branch_sequencer: three parameterisations, a behavioural branch per instance,
// table-driven layer runs with a write scoreboard, plus a mid-copy reset sequence.
module tb_branch_sequencer;

  localparam int NI = 3;
  localparam int P_NF [NI] = '{2, 1, 2};
  localparam int P_RS [NI] = '{4, 1, 4};
  localparam int P_KS [NI] = '{9, 27, 9};
  localparam int P_BB [NI] = '{100, 20, 100};
  localparam int P_OB [NI] = '{50, 300, 65534};

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    int g;       // instance
    int md;      // branch_done style: 0 pulse, 1 level, 2 stuck high, 3 pulse plus noise
    int lt;      // branch latency in cycles
    int extra;   // re-assert start while busy
    int cycles;  // expected cycles from LAUNCH through FINISH
    int last_k;  // expected kernel_base of final filter
    int last_b;  // expected bias_addr of final filter
  } vec_t;

  logic        clk;
  logic        rst;
  logic        start [NI];
  logic        busy  [NI];
  logic        done  [NI];
  logic        run   [NI];
  logic        bdone [NI];
  logic        we    [NI];
  logic [15:0] fidx  [NI];
  logic [15:0] kbase [NI];
  logic [15:0] baddr [NI];
  logic [15:0] raddr [NI];
  logic [15:0] oaddr [NI];
  logic [15:0] odata [NI];
  logic [2:0]  rsel  [NI];
  int          mode  [NI];
  int          lat   [NI];

  int n_pass = 0;
  int n_total = 0;

  function automatic logic [15:0] model_word(input logic [15:0] k, input logic [15:0] b,
                                             input logic [15:0] a);
    logic [15:0] s;
    s = 16'(k * 16'd7 + b * 16'd3 + a);
    return s ^ 16'h0500;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar g = 0; g < NI; g++) begin : g_inst
    int          cnt;
    logic        lvl;
    logic        tgl;
    logic [15:0] cap_k;
    logic [15:0] cap_b;
    logic [15:0] bres_l;

    branch_sequencer #(
      .DATA_WIDTH   (16),
      .ADDR_WIDTH   (16),
      .NUM_FILTERS  (P_NF[g]),
      .RESULT_SIZE  (P_RS[g]),
      .KERNEL_STRIDE(P_KS[g]),
      .BIAS_BASE    (P_BB[g]),
      .OUT_BASE     (P_OB[g])
    ) u_dut (
      .clk                (clk),
      .reset              (rst),
      .start              (start[g]),
      .busy               (busy[g]),
      .done               (done[g]),
      .filter_idx         (fidx[g]),
      .branch_run         (run[g]),
      .branch_done        (bdone[g]),
      .kernel_base        (kbase[g]),
      .bias_addr          (baddr[g]),
      .branch_read_select (rsel[g]),
      .branch_read_address(raddr[g]),
      .branch_result      (bres_l),
      .out_we             (we[g]),
      .out_addr           (oaddr[g]),
      .out_data           (odata[g])
    );

    assign bdone[g] = (mode[g] == 2) || (cnt == 1) || (mode[g] == 1 && lvl) ||
                      (mode[g] == 3 && cnt == 0 && tgl);

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt    <= 0;
        lvl    <= 1'b0;
        tgl    <= 1'b0;
        cap_k  <= '0;
        cap_b  <= '0;
        bres_l <= '0;
      end else begin
        tgl    <= ~tgl;
        bres_l <= (rsel[g] == 3'b100) ? model_word(cap_k, cap_b, raddr[g]) : 16'hDEAD;
        if (run[g]) begin
          cnt   <= lat[g];
          lvl   <= 1'b0;
          cap_k <= kbase[g];
          cap_b <= baddr[g];
        end else if (cnt > 0) begin
          cnt <= cnt - 1;
          if (cnt == 1) lvl <= 1'b1;
        end
      end
    end
  end

  task automatic run_vec(input vec_t v);
    wr_t         q[$];
    wr_t         w;
    int          g, cyc, runs, dones, nw, bd_cyc, act;
    logic [15:0] cur_k, cur_b;
    g = v.g;
    mode[g] = v.md;
    lat[g]  = v.lt;
    runs = 0; dones = 0; nw = 0; bd_cyc = 0; act = 0;
    cur_k = '0; cur_b = '0;
    for (int f = 0; f < P_NF[g]; f++) begin
      for (int i = 0; i < P_RS[g]; i++) begin
        w.addr = 16'(P_OB[g] + f * P_RS[g] + i);
        w.data = model_word(16'(f * P_KS[g]), 16'(P_BB[g] + f), 16'(i));
        q.push_back(w);
      end
    end
    start[g] = 1'b1;
    cyc = 0;
    while (cyc < 3000 && dones == 0) begin
      @(negedge clk);
      cyc++;
      if (bdone[g]) bd_cyc = cyc;
      if (run[g]) begin
        check("run_filter_idx", fidx[g], 32'(runs));
        check("run_kernel_base", kbase[g], 32'(16'(runs * P_KS[g])));
        check("run_bias_addr", baddr[g], 32'(16'(P_BB[g] + runs)));
        cur_k = kbase[g];
        cur_b = baddr[g];
        runs++;
      end
      if (we[g]) begin
        nw++;
        if (q.size() == 0) begin
          check("extra_write", 32'd1, 32'd0);
        end else begin
          w = q.pop_front();
          check("out_addr", oaddr[g], w.addr);
          check("out_data", odata[g], w.data);
        end
        check("kernel_base_hold", kbase[g], cur_k);
        check("bias_addr_hold", baddr[g], cur_b);
        check("read_select", rsel[g], 32'd4);
      end
      if (done[g]) dones++;
      start[g] = (dones == 0) && (v.extra != 0) && (cyc % 3 == 0);
    end
    start[g] = 1'b0;
    if (dones == 0) check("layer_timeout", 32'd0, 32'd1);
    else check("layer_cycles", cyc, v.cycles);
    check("run_count", runs, P_NF[g]);
    check("write_count", nw, P_NF[g] * P_RS[g]);
    check("missing_writes", q.size(), 32'd0);
    check("last_kernel_base", cur_k, v.last_k);
    check("last_bias_addr", cur_b, v.last_b);
    if (v.md == 0) check("done_after_branch_done", cyc - bd_cyc, P_RS[g] + 3);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (busy[g] || run[g] || we[g] || done[g]) act++;
    end
    check("idle_after_done", act, 32'd0);
  endtask

  vec_t vt [7];

  initial begin
    int cyc, act;
    vt[0] = '{0, 0, 10, 0, 35, 9, 101};
    vt[1] = '{0, 1, 3, 0, 21, 9, 101};
    vt[2] = '{0, 2, 6, 0, 17, 9, 101};
    vt[3] = '{0, 3, 5, 0, 25, 9, 101};
    vt[4] = '{0, 0, 2, 1, 19, 9, 101};
    vt[5] = '{1, 0, 6, 0, 11, 0, 20};
    vt[6] = '{2, 0, 1, 0, 17, 9, 101};

    rst = 1'b1;
    for (int g = 0; g < NI; g++) begin
      start[g] = 1'b0;
      mode[g]  = 0;
      lat[g]   = 1;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      check("reset_ctrl", {busy[g], done[g], run[g], we[g], rsel[g]}, 32'd0);
      check("reset_addr", {kbase[g], baddr[g]}, 32'd0);
      check("reset_out", {fidx[g], oaddr[g]}, 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vt[i]);

    // Abort filter 0 partway through its copy.
    mode[0] = 0;
    lat[0]  = 4;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    cyc = 0;
    while (!we[0] && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_copy", we[0], 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_ctrl", {busy[0], done[0], run[0], we[0], rsel[0]}, 32'd0);
    check("abort_addr", {kbase[0], baddr[0]}, 32'd0);
    check("abort_out", {oaddr[0], odata[0]}, 32'd0);
    check("abort_idx", {fidx[0], raddr[0]}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    act = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (we[0] || busy[0]) act++;
    end
    check("quiet_after_abort", act, 32'd0);

    run_vec(vt[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
- Sequences one DataProcessBranch over NUM_FILTERS output filters to build a complete conv layer.
- Per filter: drives the kernel base and bias address, pulses run, and waits for done.
- Then copies the pooled/ReLU result out through the branch debug read port (select 3'b100) into the layer output memory at a per-filter offset.
- Sits between the top-level layer controller and the branch.

Parameters:
- DATA_WIDTH, 16, fixed-point word width
- ADDR_WIDTH, 16, address width for all memories
- NUM_FILTERS, 4, filters (branch runs) per layer; must be >= 1
- RESULT_SIZE, 169, pooled words per filter (e.g. 13*13)
- KERNEL_STRIDE, 27, kernel words per filter in kernel memory
- BIAS_BASE, 0, bias address of filter 0
- OUT_BASE, 0, output-memory address of filter 0 result

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- start  in  1  begin layer; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on layer completion
- filter_idx  out  ADDR_WIDTH  current filter number
- branch_run  out  1  one-cycle run pulse to branch
- branch_done  in  1  branch completion (level or pulse)
- kernel_base  out  ADDR_WIDTH  filter_idx*KERNEL_STRIDE
- bias_addr  out  ADDR_WIDTH  BIAS_BASE+filter_idx
- branch_read_select  out  3  3'b100 during COPY/DRAIN, else 3'b000
- branch_read_address  out  ADDR_WIDTH  result read address
- branch_result  in  DATA_WIDTH  branch read data, 1-cycle latency
- out_we  out  1  output-memory write enable
- out_addr  out  ADDR_WIDTH  output-memory write address
- out_data  out  DATA_WIDTH  output-memory write data

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, port reset.
- Reset: every output 0; branch_read_select 3'b000; state IDLE; all counters 0. Reset mid-operation aborts immediately; no further out_we is issued.
- States: IDLE, LAUNCH, WAIT, COPY, DRAIN, NEXT, FINISH.
- IDLE: start=1 -> LAUNCH. Clear filter_idx, kernel_base, out_base_r (=OUT_BASE), and set bias_addr=BIAS_BASE.
- LAUNCH (1 cycle): branch_run=1 -> WAIT.
- WAIT: branch_done=1 -> COPY, rd_cnt=0. branch_done is ignored in all other states.
- COPY:
  - branch_read_address=rd_cnt; rd_cnt increments each cycle.
  - When rd_cnt==RESULT_SIZE-1 is issued -> DRAIN.
- Write pipeline (COPY and DRAIN):
  - The cycle after each address issue: out_we=1, out_data=branch_result, out_addr=out_base_r+(issued address).
  - The address is delayed one cycle in a register.
- DRAIN (1 cycle): performs the final write -> NEXT.
- NEXT:
  - If filter_idx==NUM_FILTERS-1 -> FINISH.
  - Else filter_idx+=1, kernel_base+=KERNEL_STRIDE, bias_addr+=1, out_base_r+=RESULT_SIZE -> LAUNCH.
  - Accumulators are used; no multipliers.
- FINISH: done=1 for one cycle -> IDLE.
- Hold and wrap rules:
  - kernel_base and bias_addr are held stable from LAUNCH through DRAIN.
  - start while busy is ignored.
  - Address arithmetic wraps modulo 2^ADDR_WIDTH; no saturation.
- Cycles per filter: 1 (LAUNCH) + branch latency + RESULT_SIZE + 1 (DRAIN) + 1 (NEXT). Plus 1 for FINISH per layer.
- Exactly RESULT_SIZE writes per filter, to contiguous addresses with no gaps or duplicates.

Decomposition:
- Package branch_seq_pkg: state enum (state_t); localparam READ_SEL_MAXRELU=3'b100 and READ_SEL_NONE=3'b000.
- One natural sub-module, result_copier: counter, 1-cycle address delay and write strobe. It has start/done handshake ports and is instantiated by branch_sequencer.

Test Plan:
- NUM_FILTERS=2, RESULT_SIZE=4, KERNEL_STRIDE=9, BIAS_BASE=100, OUT_BASE=50; start pulse, branch model asserts done 10 cycles after run -> branch_run pulses twice. kernel_base=0 then 9; bias_addr=100 then 101. out_addr 50..53 then 54..57 with data = model memory contents; done pulses once; busy low after.
- branch_done held high continuously and also pulsed during COPY -> no extra transitions; exactly 8 writes total.
- start asserted repeatedly while busy -> ignored; a single layer run, a single done.
- Reset asserted mid-COPY of filter 0 -> all outputs 0 next sample, out_we stays 0. A new start then runs cleanly from filter 0.
- NUM_FILTERS=1, RESULT_SIZE=1 -> one run, one write at OUT_BASE. Done arrives exactly 4 cycles after branch_done (COPY, DRAIN, NEXT, FINISH).
- OUT_BASE=2^ADDR_WIDTH-2, RESULT_SIZE=4 -> out_addr wraps: FFFE, FFFF, 0000, 0001.
